// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use and branch-on-load stalls, optional mult/div busy stall, stall counter.
// Latency: stall/flush outputs are combinational from the ID/EX/MEM fields; Busy starts the cycle after MulDivStart_E.
// Backpressure: STALL holds PC and IF/ID and bubbles ID/EX; a stalled taken branch does not flush IF/ID.
//
// Ports:
//   CLK, RESET                     rising-edge clock, synchronous active-high reset
//   RsAddr_D, RtAddr_D             source registers of the instruction in ID
//   RegDstAddr_E/_M, RegWriteEN_E/_M, MemToReg_E/_M   producer info in EX and MEM
//   Branch_D, BranchTaken_D        beq/bne in ID and its resolved direction
//   MulDivStart_E                  mult/div entering EX
//   STALL, StallF, StallD, FlushE  stall (all equal), FlushD taken-branch flush
//   Busy                           mult/div unit busy, StallCount saturating stall-cycle count
// Build option: define HAZARD_MULDIV_EN to include the mult/div busy state machine.

module hazard_unit #(
   parameter int MULDIV_CYCLES = 32   // busy length, legal range 2..64
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [4:0]  RsAddr_D,
   input  logic [4:0]  RtAddr_D,
   input  logic [4:0]  RegDstAddr_E,
   input  logic [4:0]  RegDstAddr_M,
   input  logic        RegWriteEN_E,
   input  logic        RegWriteEN_M,
   input  logic        MemToReg_E,
   input  logic        MemToReg_M,
   input  logic        Branch_D,
   input  logic        BranchTaken_D,
   input  logic        MulDivStart_E,
   output logic        STALL,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushE,
   output logic        FlushD,
   output logic        Busy,
   output logic [15:0] StallCount
);

   logic        lw_stall;
   logic        br_stall;
   logic        busy_raw;
   logic        stall_int;
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   // Only loads need a stall; ALU results are covered by forwarding.
   // Register 0 is never a real dependency.
   always_comb begin
      lw_stall = MemToReg_E & RegWriteEN_E & (RegDstAddr_E != 5'd0) &
                 ((RegDstAddr_E == RsAddr_D) | (RegDstAddr_E == RtAddr_D));
      br_stall = Branch_D & MemToReg_M & RegWriteEN_M & (RegDstAddr_M != 5'd0) &
                 ((RegDstAddr_M == RsAddr_D) | (RegDstAddr_M == RtAddr_D));
   end

`ifdef HAZARD_MULDIV_EN
   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter runs MULDIV_CYCLES-1 down to 0, so BUSY lasts MULDIV_CYCLES cycles.
   // Starts seen while BUSY are dropped, never reloading the counter.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_raw = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (MulDivStart_E) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_BUSY: begin
            busy_raw = 1'b1;
            if (cnt_q == 6'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
`else
   logic unused_muldiv;

   assign busy_raw      = 1'b0;
   assign unused_muldiv = MulDivStart_E ^ (MULDIV_CYCLES > 64);
`endif

   // All hazard outputs are forced low while RESET is high.
   always_comb begin
      stall_int = ~RESET & (lw_stall | br_stall | busy_raw);
      STALL     = stall_int;
      StallF    = stall_int;
      StallD    = stall_int;
      FlushE    = stall_int;
      FlushD    = ~RESET & BranchTaken_D & ~stall_int;
      Busy      = ~RESET & busy_raw;

      stall_cnt_d = stall_cnt_q;
      if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

   localparam int N = 4;
`ifdef HAZARD_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  RsAddr_D, RtAddr_D, RegDstAddr_E, RegDstAddr_M;
   logic        RegWriteEN_E, RegWriteEN_M, MemToReg_E, MemToReg_M;
   logic        Branch_D, BranchTaken_D, MulDivStart_E;
   logic        STALL, StallF, StallD, FlushE, FlushD, Busy;
   logic [15:0] StallCount;

   always #5 CLK = ~CLK;

   hazard_unit #(.MULDIV_CYCLES(N)) dut (
      .CLK(CLK), .RESET(RESET),
      .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
      .RegDstAddr_E(RegDstAddr_E), .RegDstAddr_M(RegDstAddr_M),
      .RegWriteEN_E(RegWriteEN_E), .RegWriteEN_M(RegWriteEN_M),
      .MemToReg_E(MemToReg_E), .MemToReg_M(MemToReg_M),
      .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D),
      .MulDivStart_E(MulDivStart_E),
      .STALL(STALL), .StallF(StallF), .StallD(StallD),
      .FlushE(FlushE), .FlushD(FlushD), .Busy(Busy),
      .StallCount(StallCount)
   );

   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;          // rising edges seen so far
   longint busy_start = 0;   // reference: unit busy for cyc in [busy_start, busy_until)
   longint busy_until = 0;
   int     exp_cnt = 0;

   // ---------------- reference model ----------------
   function automatic bit m_lw();
      return MemToReg_E && RegWriteEN_E && RegDstAddr_E != 0 &&
             (RegDstAddr_E == RsAddr_D || RegDstAddr_E == RtAddr_D);
   endfunction
   function automatic bit m_br();
      return Branch_D && MemToReg_M && RegWriteEN_M && RegDstAddr_M != 0 &&
             (RegDstAddr_M == RsAddr_D || RegDstAddr_M == RtAddr_D);
   endfunction
   function automatic bit m_busy();
      return MD && !RESET && cyc >= busy_start && cyc < busy_until;
   endfunction
   function automatic bit m_stall();
      return !RESET && (m_lw() || m_br() || m_busy());
   endfunction
   function automatic bit m_flushd();
      return !RESET && BranchTaken_D && !m_stall();
   endfunction

   task automatic model_edge();
      if (RESET) begin
         exp_cnt    = 0;
         busy_start = 0;
         busy_until = 0;
      end else begin
         if (m_stall() && exp_cnt < 65535) exp_cnt++;
         if (MD && MulDivStart_E && !m_busy()) begin
            busy_start = cyc + 1;
            busy_until = cyc + 1 + N;
         end
      end
      cyc++;
   endtask

   task automatic check(input string nm);
      logic [5:0] got, req;
      bit s;
      s   = m_stall();
      req = {s, s, s, s, m_flushd(), m_busy()};
      got = {STALL, StallF, StallD, FlushE, FlushD, Busy};
      tests++;
      if (got !== req || StallCount !== 16'(exp_cnt)) begin
         fails++;
         $display("FAIL %s cyc=%0d flags(stall,F,D,flushE,flushD,busy)=%b cnt=%0d required %b cnt=%0d",
                  nm, cyc, got, StallCount, req, exp_cnt);
      end
   endtask

   task automatic expect_bit(input string nm, input logic got, input logic req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, got, req);
      end
   endtask

   task automatic expect_cnt(input string nm, input logic [15:0] req);
      tests++;
      if (StallCount !== req) begin
         fails++;
         $display("FAIL %s cyc=%0d StallCount=%h required=%h", nm, cyc, StallCount, req);
      end
   endtask

   // Inputs are driven just after posedge; outputs sampled on negedge.
   task automatic step(input bit do_chk, input string nm);
      @(negedge CLK);
      if (do_chk) check(nm);
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic clr_inputs();
      RsAddr_D = 0; RtAddr_D = 0; RegDstAddr_E = 0; RegDstAddr_M = 0;
      RegWriteEN_E = 0; RegWriteEN_M = 0; MemToReg_E = 0; MemToReg_M = 0;
      Branch_D = 0; BranchTaken_D = 0; MulDivStart_E = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      RESET = 1;
      step(1, "reset");
      RESET = 0;
   endtask

   task automatic set_lw(input logic [4:0] dst, input logic [4:0] rs);
      MemToReg_E = 1; RegWriteEN_E = 1; RegDstAddr_E = dst; RsAddr_D = rs;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [4:0] rs, rt, dste, dstm;
      logic       rwe, rwm, mte, mtm, br, bt;
      logic       stall, fld;
   } vec_t;

   vec_t  tbl   [12];
   string names [12];

   function automatic vec_t mk(input logic [4:0] rs, rt, dste, dstm,
                               input logic rwe, rwm, mte, mtm, br, bt, stall, fld);
      vec_t v;
      v.rs = rs; v.rt = rt; v.dste = dste; v.dstm = dstm;
      v.rwe = rwe; v.rwm = rwm; v.mte = mte; v.mtm = mtm; v.br = br; v.bt = bt;
      v.stall = stall; v.fld = fld;
      return v;
   endfunction

   initial begin
      //                rs rt dE dM rwe rwm mte mtm br bt  stall fld
      tbl[0]  = mk(5, 0, 5, 0, 1, 0, 1, 0, 0, 0, 1, 0); names[0]  = "load_use_rs";
      tbl[1]  = mk(1, 5, 5, 0, 1, 0, 1, 0, 0, 0, 1, 0); names[1]  = "load_use_rt";
      tbl[2]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); names[2]  = "zero_guard_ex";
      tbl[3]  = mk(5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0); names[3]  = "ex_alu_prod";
      tbl[4]  = mk(5, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0); names[4]  = "ex_no_write";
      tbl[5]  = mk(0, 7, 0, 7, 0, 1, 0, 1, 1, 0, 1, 0); names[5]  = "br_load_mem";
      tbl[6]  = mk(0, 7, 0, 7, 0, 1, 0, 0, 1, 0, 0, 0); names[6]  = "br_mem_alu";
      tbl[7]  = mk(0, 7, 0, 7, 0, 1, 0, 1, 0, 0, 0, 0); names[7]  = "nobr_mem_load";
      tbl[8]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0); names[8]  = "zero_guard_mem";
      tbl[9]  = mk(1, 2, 3, 4, 1, 1, 1, 1, 1, 1, 0, 1); names[9]  = "taken_clean";
      tbl[10] = mk(3, 2, 3, 4, 1, 1, 1, 1, 1, 1, 1, 0); names[10] = "taken_lw";
      tbl[11] = mk(3, 4, 3, 4, 1, 1, 1, 1, 1, 0, 1, 0); names[11] = "lw_and_br";

      clr_inputs();
      RESET = 1;
      step(0, "reset_pre");
      step(1, "reset_hold");
      expect_bit("reset_stall", STALL, 1'b0);
      expect_cnt("reset_cnt", 16'd0);
      RESET = 0;

      // Load-use for one cycle, then idle.
      set_lw(5, 5);
      @(negedge CLK);
      expect_bit("lu_stall", STALL, 1'b1);
      expect_bit("lu_flushE", FlushE, 1'b1);
      check("lu");
      @(posedge CLK); model_edge(); #1;
      clr_inputs();
      step(1, "lu_after");
      expect_cnt("lu_cnt", 16'd1);
      // Same with destination 0: count unchanged.
      set_lw(0, 0);
      step(1, "zero_dst");
      clr_inputs();
      @(negedge CLK);
      expect_cnt("zero_dst_cnt", 16'd1);
      @(posedge CLK); model_edge(); #1;

      do_reset();
      for (int i = 0; i < 12; i++) begin
         RsAddr_D = tbl[i].rs; RtAddr_D = tbl[i].rt;
         RegDstAddr_E = tbl[i].dste; RegDstAddr_M = tbl[i].dstm;
         RegWriteEN_E = tbl[i].rwe; RegWriteEN_M = tbl[i].rwm;
         MemToReg_E = tbl[i].mte; MemToReg_M = tbl[i].mtm;
         Branch_D = tbl[i].br; BranchTaken_D = tbl[i].bt;
         @(negedge CLK);
         expect_bit({names[i], "_stall"}, STALL, tbl[i].stall);
         expect_bit({names[i], "_flushD"}, FlushD, tbl[i].fld);
         check(names[i]);
         @(posedge CLK); model_edge(); #1;
      end
      clr_inputs();
      @(negedge CLK);
      expect_cnt("table_cnt", 16'd5);
      @(posedge CLK); model_edge(); #1;

`ifdef HAZARD_MULDIV_EN
      // Single start: busy for exactly N cycles after the start cycle.
      do_reset();
      MulDivStart_E = 1;
      @(negedge CLK);
      expect_bit("md_start_busy", Busy, 1'b0);
      @(posedge CLK); model_edge(); #1;
      MulDivStart_E = 0;
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge CLK);
         expect_bit($sformatf("md_busy_c%0d", k), Busy, k <= N);
         expect_bit($sformatf("md_stall_c%0d", k), STALL, k <= N);
         @(posedge CLK); model_edge(); #1;
      end
      // Second start at cycle 2 must not extend the operation.
      MulDivStart_E = 1;
      step(1, "md2_start");
      MulDivStart_E = 0;
      for (int k = 1; k <= N + 2; k++) begin
         MulDivStart_E = (k == 2);
         @(negedge CLK);
         expect_bit($sformatf("md2_busy_c%0d", k), Busy, k <= N);
         check("md2");
         @(posedge CLK); model_edge(); #1;
      end
      MulDivStart_E = 0;
      // Reset at cycle 2 aborts.
      MulDivStart_E = 1;
      step(1, "md3_start");
      MulDivStart_E = 0;
      step(1, "md3_c1");
      RESET = 1;
      @(negedge CLK);
      expect_bit("md3_rst_busy", Busy, 1'b0);
      @(posedge CLK); model_edge(); #1;
      RESET = 0;
      @(negedge CLK);
      expect_bit("md3_after_busy", Busy, 1'b0);
      check("md3_after");
      @(posedge CLK); model_edge(); #1;
`else
      do_reset();
      MulDivStart_E = 1;
      step(1, "nomd_start");
      MulDivStart_E = 0;
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge CLK);
         expect_bit($sformatf("nomd_stall_c%0d", k), STALL, 1'b0);
         expect_bit($sformatf("nomd_busy_c%0d", k), Busy, 1'b0);
         @(posedge CLK); model_edge(); #1;
      end
`endif

      // Random traffic against the reference model.
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         RESET         = ($urandom_range(0, 99) == 0);
         RsAddr_D      = 5'($urandom_range(0, 3));
         RtAddr_D      = 5'($urandom_range(0, 3));
         RegDstAddr_E  = 5'($urandom_range(0, 3));
         RegDstAddr_M  = 5'($urandom_range(0, 3));
         RegWriteEN_E  = 1'($urandom);
         RegWriteEN_M  = 1'($urandom);
         MemToReg_E    = 1'($urandom);
         MemToReg_M    = 1'($urandom);
         Branch_D      = 1'($urandom);
         BranchTaken_D = 1'($urandom);
         MulDivStart_E = ($urandom_range(0, 15) == 0);
         step(1, "rand");
      end
      RESET = 0;

      // Saturation: constant load-use hazard.
      do_reset();
      set_lw(9, 9);
      for (int i = 0; i < 70000; i++) begin
         step(i == 0 || i == 65534 || i == 65535 || i == 69999, "sat");
      end
      @(negedge CLK);
      expect_cnt("sat_final", 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
